spi_slave_egress_packer: RTL and testbench
==========================================

SPI_SLAVE_EGRESS_PACKER -- requirements
Module: spi_slave_egress_packer

Interface
REQ-001 SHALL have parameter FRAME_BYTES, default 4: payload bytes per frame, legal range 1..31.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: byte FIFO entries; power of 2, at least FRAME_BYTES+2.
REQ-003 SHALL have parameter HEADER_TAG, default 3'b101: upper 3 bits of the header byte.
REQ-004 SHALL have port spi_clk, input, 1: the only clock; all logic on its rising edge.
REQ-005 SHALL have port resn, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1: frame word offered.
REQ-007 SHALL have port in_ready, output, 1: frame word can be accepted.
REQ-008 SHALL have port in_data, input, FRAME_BYTES*8: frame payload, byte 0 = bits [7:0].
REQ-009 SHALL have port fifo_empty, output, 1: no byte available to the egress serializer.
REQ-010 SHALL have port fifo_shift_out, input, 1: pop strobe from the egress serializer.
REQ-011 SHALL have port fifo_data, output, 8: head byte, first-word-fall-through.
REQ-012 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1: current occupancy.

Function
REQ-013 SHALL define FRAME_LEN as FRAME_BYTES+1, or FRAME_BYTES+2 with the checksum option (REQ-025).
REQ-014 SHALL define the header byte as {HEADER_TAG, FRAME_BYTES[4:0]}; the default header is 8'hA4.
REQ-015 SHALL drive in_ready = (state==IDLE) && (FIFO_DEPTH - fifo_count >= FRAME_LEN); frames are therefore atomic and never overflow.
REQ-016 SHALL accept a frame on an edge where in_valid && in_ready; on that edge latch in_data, push the header, set state to PAYLOAD and clear byte index.
REQ-017 SHALL, in PAYLOAD, push one payload byte per cycle, LSB byte first, with no stalls (space is already reserved).
REQ-018 SHALL return to IDLE on the edge that pushes the last frame byte; in_ready may rise the next cycle, so back-to-back frames have no gap.
REQ-019 SHALL have exactly two FSM states, IDLE and PAYLOAD; in_valid is ignored in PAYLOAD.
REQ-020 SHALL present the head entry on fifo_data combinationally from storage; a pop on an edge with fifo_shift_out && !fifo_empty advances the read pointer.
REQ-021 SHALL ignore a pop while empty: pointers and count unchanged, fifo_data don't-care.
REQ-022 SHALL leave the count unchanged on a simultaneous push and pop; pointers wrap modulo FIFO_DEPTH.
REQ-023 SHALL make fifo_empty and fifo_count registered-equivalent: a header pushed on edge N is visible (fifo_empty=0) in the cycle after edge N.

Reset
REQ-024 SHALL, with resn low at an edge, set state IDLE, both pointers 0, fifo_count 0 and fifo_empty 1; any partial frame is discarded, and in_ready is 1 in the cycle after resn returns high.

Configuration
REQ-025 SHALL, with SPI_EGRESS_PACKER_CHECKSUM_EN defined, append a trailer byte equal to the XOR of header and all payload bytes after the last payload byte; the header length field still equals FRAME_BYTES.
REQ-026 SHALL, without SPI_EGRESS_PACKER_CHECKSUM_EN, emit header plus payload only, with no XOR logic present.

Structure
REQ-027 SHALL take from shared package spi_egress_pkg: the FSM state enum, the default HEADER_TAG constant, and a header-byte function.
REQ-028 SHALL instantiate FIFO storage as sub-module spi_egress_byte_fifo (FWFT, push/pop/count); the FSM and checksum stay in the top.

Verification
REQ-029 SHALL verify: in_data=32'h44332211 accepted -> pops yield A4,11,22,33,44; fifo_count peaks at 5.
REQ-030 SHALL verify: SPI_EGRESS_PACKER_CHECKSUM_EN set, same frame -> A4,11,22,33,44,E0.
REQ-031 SHALL verify: no pops, 3 frames (checksum off) -> count 15, in_ready 0 with in_valid 1; after 4 pops (count 11) in_ready 1 the next cycle.
REQ-032 SHALL verify: continuous pop during PAYLOAD -> count stays constant while push and pop overlap; byte order is preserved.
REQ-033 SHALL verify: fifo_shift_out pulsed while empty -> fifo_count 0, next frame still pops A4 first.
REQ-034 SHALL verify: resn low after header+2 payload pushes -> fifo_empty 1, count 0, in_ready 1 after release; next frame intact.

Source files
------------

// File: rtl/spi_egress_pkg.sv
// Shared types and helpers for the SPI egress packer: FSM state encoding,
// default header tag and the header-byte builder.
package spi_egress_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  localparam logic [2:0] DEFAULT_HEADER_TAG = 3'b101;

  function automatic logic [7:0] header_byte(input logic [2:0] tag, input logic [4:0] len);
    return {tag, len};
  endfunction

endpackage

// File: rtl/spi_egress_byte_fifo.sv
// First-word-fall-through byte FIFO feeding the SPI egress serializer.
// Head entry is read combinationally from storage; count is registered.
module spi_egress_byte_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          resn,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    data,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A full FIFO can still take a byte on the same edge that frees one.
  assign push_ok = push && ((count != CW'(DEPTH)) || pop_ok);
  assign data    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spi_slave_egress_packer.sv
// Packs parallel frame words into header + payload bytes for the SPI egress FIFO.
// Optional XOR trailer byte when SPI_EGRESS_PACKER_CHECKSUM_EN is defined.
module spi_slave_egress_packer
  import spi_egress_pkg::*;
#(
  parameter int         FRAME_BYTES = 4,
  parameter int         FIFO_DEPTH  = 16,
  parameter logic [2:0] HEADER_TAG  = DEFAULT_HEADER_TAG
) (
  input  logic                           spi_clk,
  input  logic                           resn,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [FRAME_BYTES*8-1:0]       in_data,
  output logic                           fifo_empty,
  input  logic                           fifo_shift_out,
  output logic [7:0]                     fifo_data,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);

`ifdef SPI_EGRESS_PACKER_CHECKSUM_EN
  localparam int FRAME_LEN = FRAME_BYTES + 2;
`else
  localparam int FRAME_LEN = FRAME_BYTES + 1;
`endif
  localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
  // Index of the final byte pushed after the header.
  localparam logic [4:0] LAST_IDX = 5'(FRAME_LEN - 2);
  localparam logic [7:0] HEADER   = header_byte(HEADER_TAG, 5'(FRAME_BYTES));

  state_t                   state;
  state_t                   state_nx;
  logic [4:0]               idx;
  logic [FRAME_BYTES*8-1:0] frame;
  logic                     accept;
  logic                     push;
  logic [7:0]               push_data;
  logic [7:0]               payload_byte;

  // Whole-frame space check keeps frames atomic; no stall inside PAYLOAD.
  assign in_ready     = (state == IDLE) && ((CW'(FIFO_DEPTH) - fifo_count) >= CW'(FRAME_LEN));
  assign accept       = in_valid && in_ready;
  assign payload_byte = frame[int'(idx)*8 +: 8];

`ifdef SPI_EGRESS_PACKER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge spi_clk) begin
    if (accept)
      csum <= HEADER;
    else if ((state == PAYLOAD) && (idx != LAST_IDX))
      csum <= csum ^ payload_byte;
  end
`endif

  always_comb begin
    state_nx  = state;
    push      = 1'b0;
    push_data = HEADER;
    case (state)
      IDLE: begin
        if (accept) begin
          push     = 1'b1;
          state_nx = PAYLOAD;
        end
      end
      PAYLOAD: begin
        push      = 1'b1;
        push_data = payload_byte;
`ifdef SPI_EGRESS_PACKER_CHECKSUM_EN
        if (idx == LAST_IDX) push_data = csum;
`endif
        if (idx == LAST_IDX) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge spi_clk) begin
    if (!resn) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      if (accept)
        idx <= '0;
      else if (state == PAYLOAD)
        idx <= idx + 5'd1;
    end
  end

  always_ff @(posedge spi_clk) begin
    if (accept) frame <= in_data;
  end

  spi_egress_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (spi_clk),
    .resn      (resn),
    .push      (push),
    .push_data (push_data),
    .pop       (fifo_shift_out),
    .data      (fifo_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_spi_slave_egress_packer.sv
// Bench for spi_slave_egress_packer: directed vector table, corner sequences
// and randomized traffic checked against a queue-based byte stream model.
module tb_spi_slave_egress_packer;

  localparam int FB    = 4;
  localparam int DEPTH = 16;
`ifdef SPI_EGRESS_PACKER_CHECKSUM_EN
  localparam int FL = FB + 2;
`else
  localparam int FL = FB + 1;
`endif
  localparam logic [7:0] HDR = 8'hA4;

  logic        spi_clk = 1'b0;
  logic        resn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        fifo_empty;
  logic        fifo_shift_out;
  logic [7:0]  fifo_data;
  logic [4:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  byte unsigned fifo_m[$];
  byte unsigned pend[$];
  byte unsigned got[$];

  logic        m_fire;
  logic        m_pop;
  logic [7:0]  m_dut_byte;
  logic [31:0] m_data;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        p;
    int          cnt;
    logic        rdy;
    logic        chk_data;
    logic [7:0]  dat;
  } vec_t;
  vec_t tbl[$];

  always #5 spi_clk = ~spi_clk;

  spi_slave_egress_packer #(
    .FRAME_BYTES (FB),
    .FIFO_DEPTH  (DEPTH),
    .HEADER_TAG  (3'b101)
  ) dut (
    .spi_clk        (spi_clk),
    .resn           (resn),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .fifo_empty     (fifo_empty),
    .fifo_shift_out (fifo_shift_out),
    .fifo_data      (fifo_data),
    .fifo_count     (fifo_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Full byte stream of one frame: header, payload LSB first, optional XOR trailer.
  task automatic frame_bytes(input logic [31:0] d, output byte unsigned q[$]);
    byte unsigned cs;
    q.delete();
    q.push_back(HDR);
    cs = HDR;
    for (int k = 0; k < FB; k++) begin
      q.push_back(d[8*k +: 8]);
      cs ^= d[8*k +: 8];
    end
`ifdef SPI_EGRESS_PACKER_CHECKSUM_EN
    q.push_back(cs);
`endif
  endtask

  task automatic sample(input logic v, input logic [31:0] d, input logic p);
    logic ready_m;
    in_valid = v; in_data = d; fifo_shift_out = p;
    #1;
    ready_m = (pend.size() == 0) && ((DEPTH - fifo_m.size()) >= FL);
    chk("count", fifo_count, fifo_m.size());
    chk("empty", fifo_empty, fifo_m.size() == 0);
    chk("ready", in_ready, ready_m);
    if (fifo_m.size() > 0) chk("data", fifo_data, fifo_m[0]);
    m_fire     = resn && v && ready_m;
    m_pop      = resn && p && (fifo_m.size() > 0);
    m_dut_byte = fifo_data;
    m_data     = d;
  endtask

  task automatic tick();
    byte unsigned fb[$];
    @(posedge spi_clk);
    if (!resn) begin
      fifo_m.delete();
      pend.delete();
    end else begin
      if (m_pop) begin
        void'(fifo_m.pop_front());
        got.push_back(m_dut_byte);
      end
      if (pend.size() > 0)
        fifo_m.push_back(pend.pop_front());
      else if (m_fire) begin
        frame_bytes(m_data, fb);
        fifo_m.push_back(fb.pop_front());
        pend = fb;
      end
    end
    #1;
  endtask

  task automatic cyc(input logic v, input logic [31:0] d, input logic p);
    sample(v, d, p);
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && (fifo_m.size() > 0 || pend.size() > 0); i++) cyc(1'b0, 32'h0, 1'b1);
    chk("drain_count", fifo_count, 0);
  endtask

  task automatic expect_got(input string name, input logic [31:0] d);
    byte unsigned q[$];
    frame_bytes(d, q);
    chk({name, "_len"}, got.size(), q.size());
    for (int k = 0; k < q.size() && k < got.size(); k++) chk(name, got[k], q[k]);
    got.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nfit;
    int npop;
    byte unsigned eb[$];
    resn = 1'b0; in_valid = 1'b0; in_data = '0; fifo_shift_out = 1'b0;
    @(posedge spi_clk); #1;

    // Reset state
    cyc(1'b0, 32'h0, 1'b0);
    resn = 1'b1;
    sample(1'b0, 32'h0, 1'b0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", in_ready, 1);
    tick();

    // Table: one frame pushed with no pops, then popped out
    frame_bytes(32'h44332211, eb);
    tbl.push_back('{1'b1, 32'h44332211, 1'b0, 0, 1'b1, 1'b0, 8'h00});
    for (int i = 1; i < FL; i++) tbl.push_back('{1'b0, 32'h0, 1'b0, i, 1'b0, 1'b1, HDR});
    for (int k = 0; k < FL; k++) tbl.push_back('{1'b0, 32'h0, 1'b1, FL - k, 1'b1, 1'b1, eb[k]});
    tbl.push_back('{1'b0, 32'h0, 1'b0, 0, 1'b1, 1'b0, 8'h00});
    for (int i = 0; i < tbl.size(); i++) begin
      sample(tbl[i].v, tbl[i].d, tbl[i].p);
      chk("tbl_count", fifo_count, tbl[i].cnt);
      chk("tbl_ready", in_ready, tbl[i].rdy);
      if (tbl[i].chk_data) chk("tbl_data", fifo_data, tbl[i].dat);
      tick();
    end
    chk("tbl_b0", got[0], 8'hA4);
    chk("tbl_b4", got[4], 8'h44);
`ifdef SPI_EGRESS_PACKER_CHECKSUM_EN
    chk("tbl_trailer", got[5], 8'hE0);
`endif
    expect_got("tbl_stream", 32'h44332211);

    // Fill with back-to-back frames, no pops, until space runs out
    nfit = DEPTH / FL;
    for (int i = 0; i < nfit * FL + 3; i++) cyc(1'b1, $urandom, 1'b0);
    sample(1'b1, 32'h0, 1'b0);
    chk("full_count", fifo_count, nfit * FL);
    chk("full_ready", in_ready, 0);
    tick();
    npop = FL - (DEPTH - nfit * FL);
    for (int i = 0; i < npop; i++) cyc(1'b0, 32'h0, 1'b1);
    sample(1'b1, 32'h55667788, 1'b0);
    chk("space_count", fifo_count, DEPTH - FL);
    chk("space_ready", in_ready, 1);
    tick();
    drain();
    got.delete();

    // Pop continuously while the frame is being pushed
    cyc(1'b1, 32'hDDCCBBAA, 1'b0);
    for (int i = 1; i < FL; i++) begin
      sample(1'b0, 32'h0, 1'b1);
      chk("overlap_count", fifo_count, 1);
      tick();
    end
    drain();
    expect_got("overlap_stream", 32'hDDCCBBAA);

    // Pops while empty are ignored
    for (int i = 0; i < 3; i++) begin
      sample(1'b0, 32'h0, 1'b1);
      chk("empty_pop_count", fifo_count, 0);
      tick();
    end
    cyc(1'b1, 32'h04030201, 1'b0);
    for (int i = 1; i < FL; i++) cyc(1'b0, 32'h0, 1'b0);
    drain();
    chk("after_empty_pop_hdr", got[0], 8'hA4);
    expect_got("after_empty_pop", 32'h04030201);

    // Reset in the middle of a frame
    cyc(1'b1, 32'h0D0C0B0A, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    resn = 1'b0;
    cyc(1'b0, 32'h0, 1'b0);
    resn = 1'b1;
    sample(1'b0, 32'h0, 1'b0);
    chk("midrst_empty", fifo_empty, 1);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_ready", in_ready, 1);
    tick();
    cyc(1'b1, 32'h0D0C0B0A, 1'b0);
    for (int i = 1; i < FL; i++) cyc(1'b0, 32'h0, 1'b0);
    drain();
    expect_got("midrst_stream", 32'h0D0C0B0A);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic pv;
      pv = (i < 1000) ? ($urandom_range(0, 3) == 0) : (i < 2000) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
      resn = ($urandom_range(0, 299) != 0);
      cyc(1'($urandom_range(0, 1)), $urandom, pv);
    end
    resn = 1'b1;
    cyc(1'b0, 32'h0, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
